mux16_arbiter: RTL and testbench



---
 rtl/mux16_arbiter_if.sv | 30 +++
 rtl/mux16_arbiter.sv | 133 +++++++++++++
 tb/tb_mux16_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mux16_arbiter_if.sv
// Handshake/data bundle between two producers, the
// arbiter, and the downstream consumer.
interface mux16_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             out_ready;
  logic             gnt0;
  logic             gnt1;
  logic             ack0;
  logic             ack1;
  logic             select;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;

  modport master (
    output req0, data0, req1, data1, out_ready,
    input  gnt0, gnt1, ack0, ack1,
    input  select, out_data, out_valid
  );

  modport slave (
    input  req0, data0, req1, data1, out_ready,
    output gnt0, gnt1, ack0, ack1,
    output select, out_data, out_valid
  );
endinterface

// File: rtl/mux16_arbiter.sv
// Two-requester round-robin arbiter over a shared 2:1
// datapath with bounded hold and registered output.
module mux16_arbiter #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input logic             clk,
  input logic             rst_n,
  mux16_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             at_max;
  logic             last;
  logic             last_nxt;
  logic             sel_q;
  logic             sel_nxt;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             beat0;
  logic             beat1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last     <= 1'b1;
      sel_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state    <= nxt;
      hold_cnt <= cnt_nxt;
      last     <= last_nxt;
      sel_q    <= sel_nxt;
      valid_q  <= beat0 | beat1;
      if (beat0 | beat1)
        data_q <= sel_q ? bus.data1 : bus.data0;
    end
  end

  assign cnt_inc = hold_cnt + CNT_W'(1);
  assign at_max  = (cnt_inc == CNT_W'(MAX_HOLD));

  always_comb begin
    nxt      = state;
    cnt_nxt  = hold_cnt;
    last_nxt = last;
    beat0    = 1'b0;
    beat1    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1)
          nxt = last ? OWN0 : OWN1;
        else if (bus.req0)
          nxt = OWN0;
        else if (bus.req1)
          nxt = OWN1;
      end
      OWN0: begin
        if (!bus.req0) begin
          nxt      = bus.req1 ? OWN1 : IDLE;
          cnt_nxt  = '0;
          last_nxt = 1'b0;
        end else if (bus.out_ready) begin
          beat0 = 1'b1;
          if (at_max) begin
            cnt_nxt = '0;
            if (bus.req1) begin
              nxt      = OWN1;
              last_nxt = 1'b0;
            end
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      OWN1: begin
        if (!bus.req1) begin
          nxt      = bus.req0 ? OWN0 : IDLE;
          cnt_nxt  = '0;
          last_nxt = 1'b1;
        end else if (bus.out_ready) begin
          beat1 = 1'b1;
          if (at_max) begin
            cnt_nxt = '0;
            if (bus.req0) begin
              nxt      = OWN0;
              last_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      default: begin
        nxt     = IDLE;
        cnt_nxt = '0;
      end
    endcase
  end

  // select tracks the owner and holds through IDLE
  always_comb begin
    sel_nxt = sel_q;
    if (nxt == OWN1)
      sel_nxt = 1'b1;
    else if (nxt == OWN0)
      sel_nxt = 1'b0;
  end

  always_comb begin
    bus.gnt0      = (state == OWN0);
    bus.gnt1      = (state == OWN1);
    bus.ack0      = beat0;
    bus.ack1      = beat1;
    bus.select    = sel_q;
    bus.out_data  = data_q;
    bus.out_valid = valid_q;
  end

endmodule

// File: tb/tb_mux16_arbiter.sv
// Scoreboard bench for mux16_arbiter: random and
// directed traffic against a round-robin reference.
module tb_mux16_arbiter;

  localparam int W  = 16;
  localparam int MH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  mux16_arbiter_if #(.WIDTH(W)) bus ();

  mux16_arbiter #(
    .WIDTH(W),
    .MAX_HOLD(MH),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  logic [W-1:0] expq[$];

  // owner: 0, 1, or 2 = nobody
  int m_own  = 2;
  int m_cnt  = 0;
  int m_last = 1;
  bit m_sel  = 1'b0;
  bit m_vld  = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_own  = 2;
    m_cnt  = 0;
    m_last = 1;
    m_sel  = 1'b0;
    m_vld  = 1'b0;
    expq.delete();
  endtask

  task automatic model_update(input bit r0, input bit r1,
                              input bit rdy,
                              input logic [W-1:0] d0,
                              input logic [W-1:0] d1);
    bit req[2];
    logic [W-1:0] d[2];
    int x, y;
    bit beat;
    req[0] = r0; req[1] = r1;
    d[0] = d0;   d[1] = d1;
    beat = 1'b0;
    if (m_own == 2) begin
      if (r0 && r1) m_own = 1 - m_last;
      else if (r0)  m_own = 0;
      else if (r1)  m_own = 1;
    end else begin
      x = m_own;
      y = 1 - x;
      if (!req[x]) begin
        m_last = x;
        m_cnt  = 0;
        m_own  = req[y] ? y : 2;
      end else if (rdy) begin
        beat = 1'b1;
        expq.push_back(d[x]);
        m_cnt++;
        if (m_cnt == MH) begin
          m_cnt = 0;
          if (req[y]) begin
            m_own  = y;
            m_last = x;
          end
        end
      end
    end
    m_vld = beat;
    if (m_own == 1) m_sel = 1'b1;
    else if (m_own == 0) m_sel = 1'b0;
  endtask

  task automatic drive_check(input bit r0, input bit r1,
                             input bit rdy,
                             input logic [W-1:0] d0,
                             input logic [W-1:0] d1);
    @(negedge clk);
    bus.req0 = r0;
    bus.req1 = r1;
    bus.out_ready = rdy;
    bus.data0 = d0;
    bus.data1 = d1;
    #1;
    chk("gnt0", bus.gnt0, m_own == 0);
    chk("gnt1", bus.gnt1, m_own == 1);
    chk("select", bus.select, m_sel);
    chk("ack0", bus.ack0, m_own == 0 && r0 && rdy);
    chk("ack1", bus.ack1, m_own == 1 && r1 && rdy);
    chk("out_valid", bus.out_valid, m_vld);
  endtask

  task automatic step(input bit r0, input bit r1,
                      input bit rdy,
                      input logic [W-1:0] d0,
                      input logic [W-1:0] d1);
    drive_check(r0, r1, rdy, d0, d1);
    model_update(r0, r1, rdy, d0, d1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt0"}, bus.gnt0, 1'b0);
    chk({tag, "_gnt1"}, bus.gnt1, 1'b0);
    chk({tag, "_select"}, bus.select, 1'b0);
    chk({tag, "_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_data"}, bus.out_data, 16'h0000);
  endtask

  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (rst_n && bus.out_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL out_beat: got %0h expected none",
                 bus.out_data);
      end else begin
        e = expq.pop_front();
        chk("out_data", bus.out_data, e);
      end
    end
  end

  initial begin : driver
    int k;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.data0 = '0;
    bus.data1 = '0;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single requester
    repeat (4) step(1, 0, 1, 16'h0F00, 16'h1234);
    step(0, 0, 1, 16'h0F00, 16'h1234);
    step(0, 0, 1, 16'h0F00, 16'h1234);

    // tie and rotation
    repeat (20) step(1, 1, 1, 16'hAAAA, 16'h5555);
    repeat (2) step(0, 0, 1, 16'h0, 16'h0);

    // stall in OWN1 after 2 beats
    repeat (3) step(0, 1, 1, 16'h0101, 16'hB0B0);
    repeat (5) step(1, 1, 0, 16'h0101, 16'hB0B1);
    repeat (6) step(1, 1, 1, 16'h0102, 16'hB0B2);
    repeat (2) step(0, 0, 1, 16'h0, 16'h0);

    // early release then idle with select held
    step(1, 1, 1, 16'hC001, 16'hD001);
    step(1, 1, 1, 16'hC002, 16'hD002);
    step(0, 1, 1, 16'hC003, 16'hD003);
    step(0, 1, 1, 16'hC004, 16'hD004);
    step(0, 0, 1, 16'hC005, 16'hD005);
    step(0, 0, 1, 16'hC006, 16'hD006);
    repeat (3) step(1, 1, 1, 16'hC007, 16'hD007);
    repeat (2) step(0, 0, 1, 16'h0, 16'h0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) != 0,
           W'($urandom), W'($urandom));
    end

    // reset while ack1 is high
    k = 0;
    while (m_own != 1 && k < 6) begin
      step(0, 1, 1, 16'h7777, 16'h8888);
      k++;
    end
    chk("reach_own1", m_own, 1);
    drive_check(0, 1, 1, 16'h7777, 16'h8899);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    model_reset();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step(1, 1, 1, 16'h1111, 16'h2222);
    repeat (3) step(0, 0, 1, 16'h0, 16'h0);

    chk("queue_empty", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
